// File: rtl/sram_sync_arbiter.sv
// sram_sync_arbiter: shares one SRAM port between VGA scan-out and round-robin pixel engines during sync.
module sram_sync_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      iVGA_HS,
    input  logic                      iVGA_VS,
    input  logic                      iPause,
    input  logic [ADDR_W-1:0]         iDisp_Addr,
    input  logic [NUM_REQ-1:0]        iReq,
    input  logic [NUM_REQ-1:0]        iWr,
    input  logic [NUM_REQ*ADDR_W-1:0] iAddr,
    input  logic [NUM_REQ*DATA_W-1:0] iWdata,
    output logic [NUM_REQ-1:0]        oGnt,
    output logic [NUM_REQ-1:0]        oRvalid,
    output logic [DATA_W-1:0]         oRdata,
    output logic [NUM_REQ-1:0]        oLost,
    output logic                      oWindow,
    output logic [ADDR_W-1:0]         oSRAM_ADDR,
    output logic                      oSRAM_WE_N,
    output logic                      oSRAM_DQ_OE,
    output logic [DATA_W-1:0]         oSRAM_WDATA,
    input  logic [DATA_W-1:0]         iSRAM_RDATA
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    typedef enum logic [1:0] {DISP, ARB, XFER} state_t;
    state_t               state_q, state_d;
    logic                 win, window_q;
    logic [PW-1:0]        ptr_q, ptr_d, w, cand;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d, rvalid_q, rvalid_d, lost_q, lost_d, mask_q, mask_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 we_n_q, we_n_d;

    assign win = (~iVGA_HS | ~iVGA_VS) & ~iPause;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= DISP;
            ptr_q    <= PW'(NUM_REQ - 1);
            mask_q   <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            lost_q   <= '0;
            window_q <= 1'b0;
            rdata_q  <= '0;
            addr_q   <= '0;
            we_n_q   <= 1'b1;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            mask_q   <= mask_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            lost_q   <= lost_d;
            window_q <= win;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            we_n_q   <= we_n_d;
            wdata_q  <= wdata_d;
        end
    end

    // Descending scan so the nearest requester after ptr is the final assignment.
    always_comb begin
        w    = ptr_q;
        cand = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (iReq[cand]) w = cand;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DISP:    state_d = win ? ARB : DISP;
            ARB:     state_d = !win ? DISP : (|iReq ? XFER : ARB);
            XFER:    state_d = win ? ARB : DISP;
            default: state_d = DISP;
        endcase
    end

    always_comb begin
        ptr_d    = ptr_q;
        mask_d   = mask_q;
        gnt_d    = '0;
        rvalid_d = '0;
        lost_d   = '0;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        we_n_d   = 1'b1;
        wdata_d  = wdata_q;
        unique case (state_q)
            DISP: addr_d = iDisp_Addr;
            ARB: begin
                if (!win) begin
                    addr_d = iDisp_Addr;
                end else if (|iReq) begin
                    addr_d    = iAddr[int'(w)*ADDR_W +: ADDR_W];
                    wdata_d   = iWdata[int'(w)*DATA_W +: DATA_W];
                    we_n_d    = ~iWr[w];
                    gnt_d[w]  = 1'b1;
                    mask_d[w] = 1'b1;
                    ptr_d     = w;
                end
            end
            XFER: begin
                rdata_d  = we_n_q ? iSRAM_RDATA : rdata_q;
                rvalid_d = we_n_q ? gnt_q : '0;
                addr_d   = win ? addr_q : iDisp_Addr;
            end
            default: addr_d = iDisp_Addr;
        endcase
        if (window_q && !win) begin
            lost_d = mask_q;
            mask_d = '0;
        end
    end

    assign oGnt        = gnt_q;
    assign oRvalid     = rvalid_q;
    assign oRdata      = rdata_q;
    assign oLost       = lost_q;
    assign oWindow     = window_q;
    assign oSRAM_ADDR  = addr_q;
    assign oSRAM_WE_N  = we_n_q;
    assign oSRAM_DQ_OE = ~we_n_q;
    assign oSRAM_WDATA = wdata_q;
endmodule

// File: tb/tb_sram_sync_arbiter.sv
// tb_sram_sync_arbiter: directed checks of window gating, round-robin grants, reads/writes and lost reporting.
module tb_sram_sync_arbiter;
    logic        iCLK = 1'b0, iRST, iVGA_HS, iVGA_VS, iPause;
    logic [17:0] iDisp_Addr;
    logic [1:0]  iReq, iWr;
    logic [35:0] iAddr;
    logic [31:0] iWdata;
    logic [1:0]  oGnt, oRvalid, oLost;
    logic [15:0] oRdata, oSRAM_WDATA, iSRAM_RDATA;
    logic        oWindow, oSRAM_WE_N, oSRAM_DQ_OE;
    logic [17:0] oSRAM_ADDR;
    int          n_chk = 0, n_pass = 0;

    sram_sync_arbiter dut (
        .iCLK(iCLK), .iRST(iRST), .iVGA_HS(iVGA_HS), .iVGA_VS(iVGA_VS), .iPause(iPause),
        .iDisp_Addr(iDisp_Addr), .iReq(iReq), .iWr(iWr), .iAddr(iAddr), .iWdata(iWdata),
        .oGnt(oGnt), .oRvalid(oRvalid), .oRdata(oRdata), .oLost(oLost), .oWindow(oWindow),
        .oSRAM_ADDR(oSRAM_ADDR), .oSRAM_WE_N(oSRAM_WE_N), .oSRAM_DQ_OE(oSRAM_DQ_OE),
        .oSRAM_WDATA(oSRAM_WDATA), .iSRAM_RDATA(iSRAM_RDATA)
    );

    always #5 iCLK = ~iCLK;

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic test_reset();
        iRST = 1'b1; iVGA_HS = 1'b0; iVGA_VS = 1'b1; iPause = 1'b0;
        iDisp_Addr = 18'h00005; iReq = 2'b11; iWr = 2'b11;
        iAddr = {18'h2AAAA, 18'h15555}; iWdata = {16'hBEEF, 16'hCAFE}; iSRAM_RDATA = 16'h0;
        step(); step();
        n_chk++; if (oGnt !== 2'b00 || oRvalid !== 2'b00 || oLost !== 2'b00) $display("FAIL reset_pulses gnt=%b rvalid=%b lost=%b want 00", oGnt, oRvalid, oLost); else n_pass++;
        n_chk++; if (oWindow !== 1'b0 || oRdata !== 16'h0) $display("FAIL reset_win_rdata win=%b rdata=%h want 0/0000", oWindow, oRdata); else n_pass++;
        n_chk++; if (oSRAM_ADDR !== 18'h0 || oSRAM_WDATA !== 16'h0) $display("FAIL reset_addr_wdata addr=%h wdata=%h want 0", oSRAM_ADDR, oSRAM_WDATA); else n_pass++;
        n_chk++; if (oSRAM_WE_N !== 1'b1 || oSRAM_DQ_OE !== 1'b0) $display("FAIL reset_we we_n=%b oe=%b want 1/0", oSRAM_WE_N, oSRAM_DQ_OE); else n_pass++;
        iRST = 1'b0;
        step();
        n_chk++; if (oWindow !== 1'b1 || oGnt !== 2'b00 || oSRAM_ADDR !== 18'h00005) $display("FAIL post_reset_disp win=%b gnt=%b addr=%h want 1/00/00005", oWindow, oGnt, oSRAM_ADDR); else n_pass++;
        step();
        n_chk++; if (oGnt !== 2'b01) $display("FAIL first_grant gnt=%b want 01", oGnt); else n_pass++;
        iReq = 2'b00;
        step();
        n_chk++; if (oGnt !== 2'b00 || oSRAM_WE_N !== 1'b1) $display("FAIL first_grant_end gnt=%b we_n=%b want 00/1", oGnt, oSRAM_WE_N); else n_pass++;
    endtask

    task automatic test_write();
        iReq = 2'b01; iWr = 2'b01; iAddr[17:0] = 18'h12345; iWdata[15:0] = 16'hF000;
        step();
        n_chk++; if (oGnt !== 2'b01 || oSRAM_ADDR !== 18'h12345) $display("FAIL write_gnt gnt=%b addr=%h want 01/12345", oGnt, oSRAM_ADDR); else n_pass++;
        n_chk++; if (oSRAM_WE_N !== 1'b0 || oSRAM_DQ_OE !== 1'b1 || oSRAM_WDATA !== 16'hF000) $display("FAIL write_strobe we_n=%b oe=%b wdata=%h want 0/1/f000", oSRAM_WE_N, oSRAM_DQ_OE, oSRAM_WDATA); else n_pass++;
        iReq = 2'b00;
        step();
        n_chk++; if (oSRAM_WE_N !== 1'b1 || oSRAM_DQ_OE !== 1'b0 || oGnt !== 2'b00) $display("FAIL write_end we_n=%b oe=%b gnt=%b want 1/0/00", oSRAM_WE_N, oSRAM_DQ_OE, oGnt); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_seq [8] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        iReq = 2'b11; iWr = 2'b00;
        for (int i = 0; i < 8; i++) begin
            step();
            n_chk++; if (oGnt !== exp_seq[i]) $display("FAIL rr_seq[%0d] gnt=%b want %b", i, oGnt, exp_seq[i]); else n_pass++;
        end
        iReq = 2'b00;
        step();
    endtask

    task automatic test_read();
        iReq = 2'b10; iWr = 2'b00; iAddr[35:18] = 18'h0ABCD;
        step();
        n_chk++; if (oGnt !== 2'b10 || oSRAM_ADDR !== 18'h0ABCD || oSRAM_WE_N !== 1'b1) $display("FAIL read_gnt gnt=%b addr=%h we_n=%b want 10/0abcd/1", oGnt, oSRAM_ADDR, oSRAM_WE_N); else n_pass++;
        iReq = 2'b00; iSRAM_RDATA = 16'h8000;
        step();
        n_chk++; if (oRvalid !== 2'b10 || oRdata !== 16'h8000) $display("FAIL read_data rvalid=%b rdata=%h want 10/8000", oRvalid, oRdata); else n_pass++;
        iSRAM_RDATA = 16'h1234;
        step();
        n_chk++; if (oRvalid !== 2'b00 || oRdata !== 16'h8000) $display("FAIL read_hold rvalid=%b rdata=%h want 00/8000", oRvalid, oRdata); else n_pass++;
    endtask

    task automatic test_lost();
        iVGA_HS = 1'b1; iVGA_VS = 1'b1;
        step();
        n_chk++; if (oLost !== 2'b11 || oWindow !== 1'b0) $display("FAIL lost_all lost=%b win=%b want 11/0", oLost, oWindow); else n_pass++;
        step();
        n_chk++; if (oLost !== 2'b00) $display("FAIL lost_pulse lost=%b want 00", oLost); else n_pass++;
        iVGA_HS = 1'b0;
        step();
        iReq = 2'b01; iWr = 2'b00;
        step();
        n_chk++; if (oGnt !== 2'b01) $display("FAIL lost_gnt gnt=%b want 01", oGnt); else n_pass++;
        iReq = 2'b00; iVGA_HS = 1'b1; iDisp_Addr = 18'h0ABCD;
        step();
        n_chk++; if (oLost !== 2'b01 || oWindow !== 1'b0 || oSRAM_ADDR !== 18'h0ABCD) $display("FAIL lost_one lost=%b win=%b addr=%h want 01/0/0abcd", oLost, oWindow, oSRAM_ADDR); else n_pass++;
        iDisp_Addr = 18'h01111; iReq = 2'b11;
        n_chk++; if (oSRAM_ADDR !== 18'h0ABCD) $display("FAIL disp_latency addr=%h want 0abcd", oSRAM_ADDR); else n_pass++;
        step();
        n_chk++; if (oLost !== 2'b00 || oSRAM_ADDR !== 18'h01111) $display("FAIL disp_track lost=%b addr=%h want 00/01111", oLost, oSRAM_ADDR); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (oGnt !== 2'b00) $display("FAIL disp_nogrant[%0d] gnt=%b want 00", i, oGnt); else n_pass++;
        end
    endtask

    task automatic test_pause();
        iPause = 1'b1; iVGA_HS = 1'b0; iVGA_VS = 1'b0; iReq = 2'b11; iWr = 2'b11;
        for (int i = 0; i < 6; i++) begin
            step();
            n_chk++; if (oGnt !== 2'b00 || oSRAM_WE_N !== 1'b1 || oWindow !== 1'b0) $display("FAIL pause[%0d] gnt=%b we_n=%b win=%b want 00/1/0", i, oGnt, oSRAM_WE_N, oWindow); else n_pass++;
        end
        iPause = 1'b0; iVGA_HS = 1'b1; iVGA_VS = 1'b1; iReq = 2'b00;
        step();
    endtask

    initial begin
        test_reset();
        test_write();
        test_round_robin();
        test_read();
        test_lost();
        test_pause();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
